// File: rtl/quad_decode.sv
// quad_decode: quadrature (A/B) encoder decoder producing a one-cycle step
// pulse (en) with direction (up_dwn_n) and a sticky illegal-transition flag.
// Both pins pass through a 2-flop synchronizer. A glitch filter of FILT_LEN
// identical samples is inserted after the synchronizers only when the
// macro QUAD_FILTER_EN is defined; otherwise every synchronized sample is used.
module quad_decode #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic clr_err,
  output logic en,
  output logic up_dwn_n,
  output logic err
);

  localparam logic ST_INIT  = 1'b0;
  localparam logic ST_TRACK = 1'b1;

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("quad_decode: FILT_LEN must be at least 1");
  end

  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] fill_q;
  logic       sync_vld;

  // Accepted-sample stream feeding the tracker.
  logic [1:0] acc_val;
  logic       acc_vld;

  logic       state_q, state_d;
  logic [1:0] prev_q, prev_d;
  logic       en_q, en_d;
  logic       dir_q, dir_d;
  logic       err_q, err_d;

  // Two-flop synchronizer for the asynchronous encoder pins, {A,B} packed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {A, B};
      sync2_q <= sync1_q;
    end
  end

  // Count the synchronizer fill after reset so the reset zeros in the
  // flops are never mistaken for a real pin value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= 2'd0;
    end else if (fill_q != 2'd2) begin
      fill_q <= fill_q + 2'd1;
    end
  end

  assign sync_vld = (fill_q == 2'd2);

`ifdef QUAD_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    filt_q, filt_d;
  logic          filt_vld_q, filt_vld_d;

  // Glitch filter: a value is accepted once it has been seen FILT_LEN
  // times in a row; any shorter run is discarded.
  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    filt_d     = filt_q;
    filt_vld_d = filt_vld_q;
    if (sync_vld) begin
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        cnt_d  = CW'(1);
      end else if (cnt_q != CW'(FILT_LEN)) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_d == CW'(FILT_LEN)) begin
        filt_d     = cand_d;
        filt_vld_d = 1'b1;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q     <= 2'b00;
      cnt_q      <= '0;
      filt_q     <= 2'b00;
      filt_vld_q <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      filt_q     <= filt_d;
      filt_vld_q <= filt_vld_d;
    end
  end

  assign acc_val = filt_q;
  assign acc_vld = filt_vld_q;
`else
  assign acc_val = sync2_q;
  assign acc_vld = sync_vld;
`endif

  // Tracker: INIT captures the first accepted value, TRACK decodes Gray
  // steps. A sample arriving while en is high is deferred one cycle so en
  // can never be high on two consecutive cycles.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    en_d    = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q;
    if (clr_err) begin
      err_d = 1'b0;
    end
    case (state_q)
      ST_INIT: begin
        if (acc_vld) begin
          prev_d  = acc_val;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (acc_vld && !en_q && (acc_val != prev_q)) begin
          prev_d = acc_val;
          if (acc_val == {prev_q[0], ~prev_q[1]}) begin
            en_d  = 1'b1;
            dir_d = 1'b1;
          end else if (acc_val == {~prev_q[0], prev_q[1]}) begin
            en_d  = 1'b1;
            dir_d = 1'b0;
          end else begin
            // Both bits changed: a set here overrides a same-edge clear.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Tracker and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      prev_q  <= 2'b00;
      en_q    <= 1'b0;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign en       = en_q;
  assign up_dwn_n = dir_q;
  assign err      = err_q;

endmodule
